// File: rtl/tdlas_sweep_avg.sv
// Sweep-synchronous capture and coherent averager: accumulates 2^avg_log2 ramps point-by-point
// in RAM, then streams the averaged frame. Define TDLAS_AVG_ROUND_EN for round-half-up output.
module tdlas_sweep_avg #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_dds,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        avg_log2,
  input  logic              dc_sel,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [ACC_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [ADDR_W:0]   frame_len,
  output logic              overflow,
  output logic              len_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_ACC  = 3'd2,
    S_GAP  = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] L_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;

  logic              r_dc_q;
  logic              w_rise;
  logic              w_fall;
  logic [3:0]        r_avg;
  logic [16:0]       r_sweep;
  logic [16:0]       w_sweep_inc;
  logic              w_sweep_done;
  logic [ADDR_W:0]   r_idx;
  logic [ADDR_W:0]   r_frame_len;
  logic              r_ovf;
  logic              r_lerr;
  logic              r_busy;
  logic              w_first;
  logic              w_take;
  logic              w_in_rng;
  logic              w_wr_go;
  logic              w_in_acc;
  logic              w_in_dump;
  logic              w_wait_rise;

  logic [ACC_W-1:0]  r_mem [2**ADDR_W];
  logic [ACC_W-1:0]  r_rdata;
  logic              w_re;
  logic [ADDR_W-1:0] w_raddr;
  logic              r_p1_v;
  logic              r_p1_first;
  logic [ADDR_W-1:0] r_p1_addr;
  logic [ACC_W-1:0]  r_p1_smp;
  logic [ACC_W-1:0]  w_smp_ext;
  logic [ACC_W-1:0]  w_wdata;

  logic [ADDR_W:0]   r_rd_addr;
  logic              r_rv;
  logic              r_rlast;
  logic [ACC_W-1:0]  r_mdata;
  logic              r_mvalid;
  logic              r_mlast;
  logic              w_out_en;
  logic              w_dump_rd;
  logic [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0] w_sum_s;
  logic [ACC_W-1:0]  w_scaled;

  assign w_rise       = dc_sel & ~r_dc_q;
  assign w_fall       = ~dc_sel & r_dc_q;
  assign w_first      = (r_sweep == 17'd0);
  assign w_sweep_inc  = r_sweep + 17'd1;
  assign w_sweep_done = (w_sweep_inc == (17'd1 << r_avg));
  assign w_take       = w_in_acc & adc_valid & dc_sel;
  // sweep 0 fills up to the RAM depth; later sweeps only touch points sweep 0 defined
  assign w_in_rng     = w_first ? ~r_idx[ADDR_W] : (r_idx < r_frame_len);
  assign w_wr_go      = w_take & w_in_rng;
  assign w_smp_ext    = {{(ACC_W-DATA_W){adc_data[DATA_W-1]}}, adc_data};
  assign w_wdata      = r_p1_first ? r_p1_smp : (r_rdata + r_p1_smp);

  assign w_out_en  = ~r_mvalid | m_ready;
  assign w_dump_rd = w_in_dump & (r_rd_addr < r_frame_len) & (~r_rv | w_out_en);
  assign w_re      = (w_wr_go & ~w_first) | w_dump_rd;
  assign w_raddr   = w_in_dump ? r_rd_addr[ADDR_W-1:0] : r_idx[ADDR_W-1:0];

`ifdef TDLAS_AVG_ROUND_EN
  assign w_rnd = (r_avg == 4'd0) ? {ACC_W{1'b0}} : ({{(ACC_W-1){1'b0}}, 1'b1} << (r_avg - 4'd1));
`else
  assign w_rnd = {ACC_W{1'b0}};
`endif
  assign w_sum_s  = r_rdata + w_rnd;
  assign w_scaled = w_sum_s >>> r_avg;

  assign m_data    = r_mdata;
  assign m_valid   = r_mvalid;
  assign m_last    = r_mlast;
  assign busy      = r_busy;
  assign frame_len = r_frame_len;
  assign overflow  = r_ovf;
  assign len_err   = r_lerr;

  always_ff @(posedge clk_dds) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ARM;
        else       w_next = S_IDLE;
      end
      S_ARM, S_GAP: begin
        if (w_rise) w_next = S_ACC;
        else        w_next = r_state;
      end
      S_ACC: begin
        if (w_fall) w_next = w_sweep_done ? S_DUMP : S_GAP;
        else        w_next = S_ACC;
      end
      S_DUMP: begin
        if ((r_frame_len == '0) || (r_mvalid & m_ready & r_mlast)) w_next = S_IDLE;
        else                                                     w_next = S_DUMP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_acc    = 1'b0;
    w_in_dump   = 1'b0;
    w_wait_rise = 1'b0;
    case (r_state)
      S_ACC:        w_in_acc    = 1'b1;
      S_DUMP:       w_in_dump   = 1'b1;
      S_ARM, S_GAP: w_wait_rise = 1'b1;
      default:      w_in_acc    = 1'b0;
    endcase
  end

  always_ff @(posedge clk_dds) begin
    if (rst) begin
      r_dc_q      <= 1'b0;
      r_avg       <= 4'd0;
      r_sweep     <= 17'd0;
      r_idx       <= '0;
      r_frame_len <= '0;
      r_ovf       <= 1'b0;
      r_lerr      <= 1'b0;
    end else begin
      r_dc_q <= dc_sel;
      if ((r_state == S_IDLE) && start) begin
        r_avg       <= avg_log2;
        r_sweep     <= 17'd0;
        r_ovf       <= 1'b0;
        r_lerr      <= 1'b0;
        r_frame_len <= '0;
      end
      if (w_wait_rise && w_rise) begin
        r_idx <= '0;
      end else if (w_take) begin
        // index saturates so a runaway sweep still reports a length mismatch
        if (w_first) begin
          if (!r_idx[ADDR_W]) r_idx <= r_idx + L_ONE;
          else                r_ovf <= 1'b1;
        end else if (r_idx != '1) begin
          r_idx <= r_idx + L_ONE;
        end
      end
      if (w_in_acc && w_fall) begin
        r_sweep <= w_sweep_inc;
        if (w_first)                   r_frame_len <= r_idx;
        else if (r_idx != r_frame_len) r_lerr      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_dds) begin
    if (rst) r_p1_v <= 1'b0;
    else     r_p1_v <= w_wr_go;
    r_p1_first <= w_first;
    r_p1_addr  <= r_idx[ADDR_W-1:0];
    r_p1_smp   <= w_smp_ext;
  end

  always_ff @(posedge clk_dds) begin
    if (r_p1_v) r_mem[r_p1_addr] <= w_wdata;
    if (w_re)   r_rdata <= r_mem[w_raddr];
  end

  // readout: RAM data register feeds a stallable output register
  always_ff @(posedge clk_dds) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_rv      <= 1'b0;
      r_rlast   <= 1'b0;
      r_mdata   <= '0;
      r_mvalid  <= 1'b0;
      r_mlast   <= 1'b0;
    end else if (!w_in_dump) begin
      r_rd_addr <= '0;
      r_rv      <= 1'b0;
      r_mvalid  <= 1'b0;
      r_mlast   <= 1'b0;
    end else begin
      if (w_dump_rd) begin
        r_rd_addr <= r_rd_addr + L_ONE;
        r_rlast   <= (r_rd_addr == (r_frame_len - L_ONE));
        r_rv      <= 1'b1;
      end else if (w_out_en) begin
        r_rv <= 1'b0;
      end
      if (w_out_en) begin
        r_mvalid <= r_rv;
        r_mlast  <= r_rv & r_rlast;
        if (r_rv) r_mdata <= w_scaled;
      end
    end
  end

endmodule

// File: tb/tb_tdlas_sweep_avg.sv
// Directed self-checking bench for tdlas_sweep_avg (ADDR_W=4 so the overflow case stays short).
module tb_tdlas_sweep_avg;

  logic        clk_dds = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  avg_log2 = 4'd0;
  logic        dc_sel = 1'b0;
  logic [15:0] adc_data = 16'd0;
  logic        adc_valid = 1'b0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;
  logic [4:0]  frame_len;
  logic        overflow;
  logic        len_err;

  int     n_checks = 0;
  int     n_errors = 0;
  int     samp [0:31];
  longint exp_v [0:31];
  longint got [0:63];
  bit     got_last [0:63];
  int     n_beats;

  tdlas_sweep_avg #(.DATA_W(16), .ACC_W(32), .ADDR_W(4)) dut (
    .clk_dds(clk_dds), .rst(rst), .start(start), .avg_log2(avg_log2),
    .dc_sel(dc_sel), .adc_data(adc_data), .adc_valid(adc_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .frame_len(frame_len), .overflow(overflow), .len_err(len_err)
  );

  always #5 clk_dds = ~clk_dds;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dds);
    #1;
  endtask

  task automatic arm(input int avg);
    avg_log2 = 4'(avg);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // one ramp: rise cycle without data, n samples, then two idle cycles
  task automatic sweep(input int n);
    dc_sel = 1'b1;
    adc_valid = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data = 16'(samp[i]);
      tick();
    end
    adc_valid = 1'b0;
    dc_sel = 1'b0;
    tick();
    tick();
  endtask

  task automatic collect(input bit rnd, input bit poke);
    int     cyc;
    bit     prev_stall;
    longint prev_data;
    n_beats = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = 0;
    while (busy && cyc < 400) begin
      if (prev_stall) begin
        check_eq("hold_valid", longint'(m_valid), 1);
        check_eq("hold_data", longint'(m_data), prev_data);
      end
      m_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      start = poke && (n_beats == 2) && m_valid;
      if (m_valid && m_ready && n_beats < 64) begin
        got[n_beats] = longint'($signed(m_data));
        got_last[n_beats] = m_last;
        n_beats++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = longint'(m_data);
      tick();
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b0;
    check_eq("dump_done", longint'(cyc < 400), 1);
  endtask

  task automatic verify_frame(input string tag, input int n_exp);
    check_eq({tag, "_beats"}, n_beats, n_exp);
    for (int i = 0; i < n_exp && i < n_beats; i++) begin
      check_eq({tag, "_data"}, got[i], exp_v[i]);
      check_eq({tag, "_last"}, longint'(got_last[i]), longint'(i == n_exp - 1));
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_m_data", longint'(m_data), 0);
    check_eq("rst_m_valid", longint'(m_valid), 0);
    check_eq("rst_m_last", longint'(m_last), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_frame_len", longint'(frame_len), 0);
    check_eq("rst_overflow", longint'(overflow), 0);
    check_eq("rst_len_err", longint'(len_err), 0);

    // basic average, start pulse during DUMP must be ignored
    arm(2);
    check_eq("busy_rise", longint'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) samp[i] = 4 * i + k;
      sweep(8);
    end
`ifdef TDLAS_AVG_ROUND_EN
    for (int i = 0; i < 8; i++) exp_v[i] = 4 * i + 2;
`else
    for (int i = 0; i < 8; i++) exp_v[i] = 4 * i + 1;
`endif
    collect(1'b0, 1'b1);
    verify_frame("basic", 8);
    check_eq("basic_frame_len", longint'(frame_len), 8);
    check_eq("basic_len_err", longint'(len_err), 0);
    check_eq("basic_busy_fall", longint'(busy), 0);

    // signed data: -3 then -2
    arm(1);
    samp[0] = -3;
    sweep(1);
    samp[0] = -2;
    sweep(1);
`ifdef TDLAS_AVG_ROUND_EN
    exp_v[0] = -2;
`else
    exp_v[0] = -3;
`endif
    collect(1'b0, 1'b0);
    verify_frame("signed", 1);

    // length mismatch: 10 then 12 points
    arm(1);
    for (int i = 0; i < 12; i++) samp[i] = i + 100;
    sweep(10);
    for (int i = 0; i < 12; i++) samp[i] = (i < 10) ? i + 200 : 30000;
    sweep(12);
    for (int i = 0; i < 10; i++) exp_v[i] = i + 150;
    collect(1'b0, 1'b0);
    verify_frame("lenerr", 10);
    check_eq("lenerr_flag", longint'(len_err), 1);
    check_eq("lenerr_frame_len", longint'(frame_len), 10);

    // overflow: 20 points into 16-deep RAM
    arm(0);
    for (int i = 0; i < 20; i++) samp[i] = 7 * i - 50;
    sweep(20);
    for (int i = 0; i < 16; i++) exp_v[i] = 7 * i - 50;
    collect(1'b0, 1'b0);
    verify_frame("ovf", 16);
    check_eq("ovf_flag", longint'(overflow), 1);
    check_eq("ovf_frame_len", longint'(frame_len), 16);
    check_eq("ovf_len_err", longint'(len_err), 0);

    // backpressure with pseudo-random ready
    arm(1);
    for (int i = 0; i < 12; i++) samp[i] = 3 * i;
    sweep(12);
    for (int i = 0; i < 12; i++) samp[i] = 1 - 5 * i;
    sweep(12);
`ifdef TDLAS_AVG_ROUND_EN
    for (int i = 0; i < 12; i++) exp_v[i] = 1 - i;
`else
    for (int i = 0; i < 12; i++) exp_v[i] = -i;
`endif
    collect(1'b1, 1'b0);
    verify_frame("bp", 12);

    // empty sweep: frame_len 0 gives no beats
    arm(0);
    sweep(0);
    collect(1'b0, 1'b0);
    check_eq("empty_beats", n_beats, 0);
    check_eq("empty_busy", longint'(busy), 0);

    // start while a ramp is already running: that ramp is skipped
    dc_sel = 1'b1;
    tick();
    tick();
    arm(0);
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data = 16'd999;
      tick();
    end
    adc_valid = 1'b0;
    dc_sel = 1'b0;
    tick();
    tick();
    check_eq("skip_busy", longint'(busy), 1);
    check_eq("skip_frame_len", longint'(frame_len), 0);
    samp[0] = 11;
    samp[1] = 12;
    samp[2] = 13;
    sweep(3);
    for (int i = 0; i < 3; i++) exp_v[i] = 11 + i;
    collect(1'b0, 1'b0);
    verify_frame("skip", 3);

    // reset in the middle of the second sweep
    arm(1);
    for (int i = 0; i < 4; i++) samp[i] = i;
    sweep(4);
    dc_sel = 1'b1;
    tick();
    adc_valid = 1'b1;
    adc_data = 16'd5;
    tick();
    check_eq("pre_rst_busy", longint'(busy), 1);
    check_eq("pre_rst_frame_len", longint'(frame_len), 4);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_busy", longint'(busy), 0);
    check_eq("mid_rst_frame_len", longint'(frame_len), 0);
    check_eq("mid_rst_m_valid", longint'(m_valid), 0);
    check_eq("mid_rst_m_data", longint'(m_data), 0);
    check_eq("mid_rst_m_last", longint'(m_last), 0);
    check_eq("mid_rst_overflow", longint'(overflow), 0);
    check_eq("mid_rst_len_err", longint'(len_err), 0);
    rst = 1'b0;
    adc_valid = 1'b0;
    dc_sel = 1'b0;
    tick();
    tick();
    check_eq("post_rst_busy", longint'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
